// File: rtl/read_ctrl_pkg.sv
// Shared definitions for the consumer-side read controller.
// State encoding and default widths used by read_controller and its counters.
package read_ctrl_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_LEN_W      = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      CAPTURE = 3'd2,
      LOAD    = 3'd3,
      VALID   = 3'd4,
      DONE    = 3'd5
   } state_t;

endpackage

// File: rtl/rd_burst_counter.sv
// Down counter with synchronous load, saturating decrement and zero flag.
// Serves as the remaining-word counter and, optionally, the empty-stall timer.
module rd_burst_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Load wins over decrement; decrement stops at zero so the count never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/read_controller.sv
// Burst read controller: fetches r_len words from the shared buffer and hands them
// to the consumer over valid/ack. Define READ_TIMEOUT_EN to add the empty-stall abort (err).
module read_controller
   import read_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int LEN_W      = DEFAULT_LEN_W
`ifdef READ_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  r_en,
   input  logic [LEN_W-1:0]      r_len,
   input  logic                  r_ack,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] buff_dout,
   output logic                  buff_r,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  valid,
   output logic                  busy,
   output logic                  done
`ifdef READ_TIMEOUT_EN
   ,
   output logic                  err
`endif
);

   state_t           state, state_next;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [LEN_W-1:0] cnt_load_val;

`ifdef READ_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
   logic stall_load, stall_dec, stall_zero, timeout;
`endif

   rd_burst_counter #(.W(LEN_W)) u_count (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next   = state;
      cnt_load     = 1'b0;
      cnt_load_val = r_len;
      cnt_dec      = 1'b0;
`ifdef READ_TIMEOUT_EN
      timeout      = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (r_en) begin
               if (r_len != '0) begin
                  cnt_load   = 1'b1;
                  state_next = REQ;
               end else begin
                  state_next = DONE;
               end
            end
         end
         REQ: begin
            if (!empty) begin
               state_next = CAPTURE;
            end
`ifdef READ_TIMEOUT_EN
            else if (stall_zero) begin
               state_next   = IDLE;
               cnt_load     = 1'b1;
               cnt_load_val = '0;
               timeout      = 1'b1;
            end
`endif
         end
         CAPTURE: state_next = LOAD;
         LOAD: begin
            cnt_dec    = 1'b1;
            state_next = VALID;
         end
         VALID: begin
            if (r_ack) state_next = cnt_zero ? DONE : REQ;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The buffer's read port is registered, so its data is taken one cycle after the strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              dout <= '0;
      else if (state == LOAD)  dout <= buff_dout;
   end

   assign buff_r = (state == CAPTURE);
   assign valid  = (state == VALID);
   assign busy   = (state != IDLE);
   assign done   = (state == DONE);

`ifdef READ_TIMEOUT_EN
   // Stall timer is armed on each entry to REQ and runs down only while the buffer is empty.
   assign stall_load = (state_next == REQ) && (state != REQ);
   assign stall_dec  = (state == REQ) && empty;

   rd_burst_counter #(.W(STALL_W)) u_stall (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (stall_load),
      .load_val (STALL_W'(TIMEOUT_CYCLES - 1)),
      .dec      (stall_dec),
      .zero     (stall_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err <= 1'b0;
      else        err <= timeout;
   end
`endif

endmodule

// File: doc/read_controller.md
Name: read_controller

Overview:
- Consumer-side controller for the shared word buffer; the counterpart of the producer-side write path.
- Accepts a burst-read request of r_len words and pulses buff_r once per word while the buffer is non-empty.
- Captures each word from the buffer's registered read port and presents it to the consumer with a valid/ack handshake.
- Signals completion with a one-cycle done pulse.

Parameters:
- DATA_WIDTH, 8, width of buffer words and dout.
- LEN_W, 4, width of r_len and of the internal remaining-word counter; max burst 2^LEN_W-1.
- TIMEOUT_CYCLES, 16, empty-stall limit; used only when READ_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- r_en  input  1  burst request, sampled in IDLE only.
- r_len  input  LEN_W  burst length, sampled with r_en.
- r_ack  input  1  consumer has taken dout.
- empty  input  1  buffer empty flag.
- buff_dout  input  DATA_WIDTH  buffer read data, valid one cycle after buff_r.
- buff_r  output  1  buffer read strobe, one cycle per word.
- dout  output  DATA_WIDTH  captured word.
- valid  output  1  dout holds an unconsumed word.
- busy  output  1  burst in progress (state != IDLE).
- done  output  1  one-cycle end-of-burst pulse.
- err  output  1  timeout abort pulse; port exists only with READ_TIMEOUT_EN.

Behaviour:
- Single clock clk; reset is asynchronous and active-low on rst_n.
- Reset, immediate on rst_n low: state=IDLE, count=0, dout=0, and buff_r, valid, busy, done, err all 0. Reset mid-burst abandons the burst; no done is issued.
- All outputs are registered or decoded from state only, Moore style; no input-to-output combinational path.
- State IDLE:
  - If r_en=1 and r_len!=0: load count<=r_len and go to REQ.
  - If r_en=1 and r_len=0: go to DONE, with no buffer access.
  - Otherwise stay in IDLE.
- State REQ: if empty=0, go to CAPTURE; otherwise stay in REQ. buff_r is 0 in REQ.
- State CAPTURE:
  - buff_r=1 for exactly this cycle. CAPTURE is entered only from REQ with empty=0, so the buffer is never read when empty.
  - Next state is LOAD.
- State LOAD: dout<=buff_dout; count<=count-1; go to VALID.
- State VALID:
  - valid=1 and dout is held stable.
  - On r_ack=1: go to REQ if count!=0, else go to DONE.
  - r_ack while valid=0 is ignored.
- State DONE: done=1 for one cycle, then go to IDLE.
- r_en is ignored while busy=1; a new request is accepted no earlier than the cycle after done.
- Latency, buffer non-empty and r_ack tied high:
  - Word 1 is valid 4 cycles after the r_en sample edge (REQ, CAPTURE, LOAD, VALID).
  - Each subsequent word takes 4 cycles.
  - done follows the last ack by 1 cycle.
- empty rising during a burst: the controller stalls in REQ indefinitely (no timeout build) with valid=0 and busy=1.
- The counter never wraps: it decrements only in LOAD and only from count>=1.

Optional Feature:
- Macro: READ_TIMEOUT_EN.
- Defined:
  - A stall counter increments each cycle spent in REQ with empty=1 and clears on leaving REQ.
  - When it reaches TIMEOUT_CYCLES, the controller goes to IDLE with a one-cycle err pulse and no done; count is cleared.
  - The err port is present.
- Undefined: no stall counter and no err port; REQ waits forever.

Decomposition:
- Shared package read_ctrl_pkg holds:
  - State encoding constants: IDLE, REQ, CAPTURE, LOAD, VALID, DONE (3-bit).
  - Default DATA_WIDTH and LEN_W values.
- One natural sub-module: rd_burst_counter.
  - LEN_W-bit counter with load, decrement and zero flag.
  - Reused for the timeout stall counter when READ_TIMEOUT_EN is defined.

Test Plan:
- Single read: buffer holds 0xA5, r_len=1, r_en pulse, r_ack held 1 -> one buff_r pulse; valid with dout=0xA5 4 cycles after the request; done 1 cycle after the ack; busy then 0.
- Burst: buffer holds 0x11, 0x22, 0x33; r_len=3; r_ack delayed 2 cycles per word -> exactly 3 buff_r pulses; dout sequence 0x11, 0x22, 0x33; each held stable until acked; one done.
- Empty stall: r_len=2, buffer empty for 10 cycles, then 0x5A pushed -> no buff_r while empty; 0x5A delivered afterwards; busy high throughout.
- Zero length: r_len=0 with r_en -> done the next cycle; buff_r never asserted.
- Reset mid-burst: rst_n low while in VALID with r_len=3 -> valid, busy and buff_r drop asynchronously; no done; a fresh r_len=1 request afterwards succeeds.
- Timeout (READ_TIMEOUT_EN, TIMEOUT_CYCLES=16): empty held high -> err pulses once 16 cycles after entering REQ; return to IDLE; done stays 0.
